// File: rtl/fb_text_ctrl_if.sv
// Command and framebuffer-write bundle for the text-mode framebuffer controller.
// The master side issues commands; the slave side (the controller) drives the
// framebuffer write port, cursor position and busy status.
interface fb_text_ctrl_if #(
  parameter int AW = 13
);
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [1:0]    i_cmd;
  logic [7:0]    i_data;
  logic [12:0]   i_arg;
  logic          o_fb_we;
  logic [AW-1:0] o_fb_addr;
  logic [7:0]    o_fb_data;
  logic [6:0]    o_cur_x;
  logic [5:0]    o_cur_y;
  logic          o_busy;

  modport master (
    output i_cmd_valid, i_cmd, i_data, i_arg,
    input  o_cmd_ready, o_fb_we, o_fb_addr, o_fb_data, o_cur_x, o_cur_y, o_busy
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_data, i_arg,
    output o_cmd_ready, o_fb_we, o_fb_addr, o_fb_data, o_cur_x, o_cur_y, o_busy
  );
endinterface

// File: rtl/fb_text_ctrl.sv
// Text-mode framebuffer controller: accepts character/cursor/clear/config
// commands and turns them into single-cycle framebuffer write strobes.
// Screen clears and the row wipe on scroll-wrap are multi-cycle fills that
// hold off new commands until the last cell has been written.
module fb_text_ctrl #(
  parameter int         HTILES    = 80,
  parameter int         VTILES    = 60,
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter int         AW        = 13
) (
  input  logic        px_clk,
  input  logic        rst,
  fb_text_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL_ALL = 2'd1,
    FILL_ROW = 2'd2
  } state_t;

  localparam logic [6:0]    X_MAX     = 7'(HTILES - 1);
  localparam logic [5:0]    Y_MAX     = 6'(VTILES - 1);
  localparam logic [AW-1:0] HT_W      = AW'(HTILES);
  localparam logic [AW-1:0] CELL_LAST = AW'(HTILES * VTILES - 1);
  localparam logic [AW-1:0] ROW_LAST  = AW'(HTILES - 1);
  localparam logic [AW-1:0] CFG_BASE  = AW'(HTILES * VTILES);

  state_t        state_r, state_s;
  logic [6:0]    cur_x_r, cur_x_s;
  logic [5:0]    cur_y_r, cur_y_s;
  logic          fb_we_r, fb_we_s;
  logic [AW-1:0] fb_addr_r, fb_addr_s;
  logic [7:0]    fb_data_r, fb_data_s;
  logic [AW-1:0] fill_cnt_r, fill_cnt_s;
  logic [7:0]    fill_data_r, fill_data_s;
  logic          ready_s;
  logic          accept_s;
  logic          row_adv_s;
  logic [AW-1:0] cell_addr_s;
  logic [6:0]    arg_x_s;
  logic [5:0]    arg_y_s;
  logic [4:0]    cfg_idx_s;

  // Commands are only taken when idle and never while reset is asserted.
  assign ready_s     = (state_r == IDLE) && !rst;
  assign accept_s    = bus.i_cmd_valid && ready_s;
  assign cell_addr_s = AW'(cur_y_r) * HT_W + AW'(cur_x_r);
  assign arg_x_s     = bus.i_arg[6:0];
  assign arg_y_s     = bus.i_arg[12:7];
  assign cfg_idx_s   = bus.i_arg[4:0];

  assign bus.o_cmd_ready = ready_s;
  assign bus.o_busy      = (state_r != IDLE);
  assign bus.o_fb_we     = fb_we_r;
  assign bus.o_fb_addr   = fb_addr_r;
  assign bus.o_fb_data   = fb_data_r;
  assign bus.o_cur_x     = cur_x_r;
  assign bus.o_cur_y     = cur_y_r;

  // Next-state, cursor and write-port decode for command handling and fills.
  always_comb begin
    state_s     = state_r;
    cur_x_s     = cur_x_r;
    cur_y_s     = cur_y_r;
    fb_we_s     = 1'b0;
    fb_addr_s   = fb_addr_r;
    fb_data_s   = fb_data_r;
    fill_cnt_s  = fill_cnt_r;
    fill_data_s = fill_data_r;
    row_adv_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (bus.i_cmd)
            2'd0: begin
              case (bus.i_data)
                8'h0A: begin
                  cur_x_s   = 7'd0;
                  row_adv_s = 1'b1;
                end
                8'h0D: cur_x_s = 7'd0;
                8'h08: begin
                  if (cur_x_r != 7'd0) begin
                    cur_x_s = cur_x_r - 7'd1;
                  end else begin
                    cur_x_s = cur_x_r;
                  end
                end
                default: begin
                  fb_we_s   = 1'b1;
                  fb_addr_s = cell_addr_s;
                  fb_data_s = bus.i_data;
                  if (cur_x_r == X_MAX) begin
                    cur_x_s   = 7'd0;
                    row_adv_s = 1'b1;
                  end else begin
                    cur_x_s = cur_x_r + 7'd1;
                  end
                end
              endcase
              // Wrapping off the bottom row lands on row 0, which gets wiped.
              if (row_adv_s) begin
                if (cur_y_r < Y_MAX) begin
                  cur_y_s = cur_y_r + 6'd1;
                end else begin
                  cur_y_s    = 6'd0;
                  state_s    = FILL_ROW;
                  fill_cnt_s = {AW{1'b0}};
                end
              end else begin
                cur_y_s = cur_y_r;
              end
            end
            2'd1: begin
              cur_x_s = (arg_x_s > X_MAX) ? X_MAX : arg_x_s;
              cur_y_s = (arg_y_s > Y_MAX) ? Y_MAX : arg_y_s;
            end
            2'd2: begin
              state_s     = FILL_ALL;
              fill_cnt_s  = {AW{1'b0}};
              fill_data_s = bus.i_data;
              cur_x_s     = 7'd0;
              cur_y_s     = 6'd0;
            end
            2'd3: begin
              if (cfg_idx_s < 5'd18) begin
                fb_we_s   = 1'b1;
                fb_addr_s = CFG_BASE + AW'(cfg_idx_s);
                fb_data_s = bus.i_data;
              end else begin
                fb_we_s = 1'b0;
              end
            end
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      FILL_ALL: begin
        fb_we_s   = 1'b1;
        fb_addr_s = fill_cnt_r;
        fb_data_s = fill_data_r;
        if (fill_cnt_r == CELL_LAST) begin
          state_s    = IDLE;
          fill_cnt_s = {AW{1'b0}};
        end else begin
          fill_cnt_s = fill_cnt_r + AW'(1);
        end
      end
      FILL_ROW: begin
        fb_we_s   = 1'b1;
        fb_addr_s = fill_cnt_r;
        fb_data_s = FILL_CHAR;
        if (fill_cnt_r == ROW_LAST) begin
          state_s    = IDLE;
          fill_cnt_s = {AW{1'b0}};
        end else begin
          fill_cnt_s = fill_cnt_r + AW'(1);
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and output registers; reset abandons any fill in progress.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cur_x_r     <= 7'd0;
      cur_y_r     <= 6'd0;
      fb_we_r     <= 1'b0;
      fb_addr_r   <= {AW{1'b0}};
      fb_data_r   <= 8'd0;
      fill_cnt_r  <= {AW{1'b0}};
      fill_data_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      cur_x_r     <= cur_x_s;
      cur_y_r     <= cur_y_s;
      fb_we_r     <= fb_we_s;
      fb_addr_r   <= fb_addr_s;
      fb_data_r   <= fb_data_s;
      fill_cnt_r  <= fill_cnt_s;
      fill_data_r <= fill_data_s;
    end
  end

endmodule
